// File: rtl/drum_prod_expander.sv
// drum_prod_expander: back end of the DRUM approximate multiplier.
// Takes the fragment product and the two truncation shifts from the front
// end and re-expands them to the full 2N-bit approximate product,
// frac << (sh_a + sh_b), through a two-stage valid/ready pipeline.
// Optional feature macro: DRUM_EXP_PERF_CNT_EN adds a 32-bit perf_cnt port
// counting completed output transfers.
module drum_prod_expander #(
    parameter int N   = 16,
    parameter int K   = 6,
    parameter int SHW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*K-1:0]       in_frac,
    input  logic [SHW-1:0]       in_sh_a,
    input  logic [SHW-1:0]       in_sh_b,
    input  logic                 in_zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*N-1:0]       out_prod
`ifdef DRUM_EXP_PERF_CNT_EN
    ,
    output logic [31:0]          perf_cnt
`endif
);

    localparam int FW = 2 * K;   // fragment product width
    localparam int PW = 2 * N;   // full product width
    localparam int SW = SHW + 1; // summed shift width, cannot overflow

    // Stage 1: masked fragment and summed shift
    logic            s1_valid_q, s1_valid_d;
    logic [FW-1:0]   s1_frac_q,  s1_frac_d;
    logic [SW-1:0]   s1_sum_q,   s1_sum_d;

    // Stage 2: expanded product, drives the output directly
    logic            s2_valid_q, s2_valid_d;
    logic [PW-1:0]   out_prod_q, out_prod_d;

    logic            s1_adv;
    logic            s2_adv;
    logic [PW-1:0]   frac_ext;
    logic [PW-1:0]   shifted;

    // Stall chain: a stage moves when it is empty or its successor moves.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;
    end

    // Zero-extend the fragment to the full width, then shift; bits pushed
    // past the MSB are simply lost, which is the defined overshoot behaviour.
    always_comb begin
        frac_ext          = '0;
        frac_ext[FW-1:0]  = s1_frac_q;
        shifted           = frac_ext << s1_sum_q;
    end

    // Next-state for both stages; registers hold unless their stage advances.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_frac_d  = s1_frac_q;
        s1_sum_d   = s1_sum_q;
        s2_valid_d = s2_valid_q;
        out_prod_d = out_prod_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_frac_d = in_zero ? '0 : in_frac;
                s1_sum_d  = {1'b0, in_sh_a} + {1'b0, in_sh_b};
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_prod_d = shifted;
            end
        end
    end

    // Pipeline registers; reset discards any in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_frac_q  <= '0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            out_prod_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_frac_q  <= s1_frac_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            out_prod_q <= out_prod_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_prod  = out_prod_q;

`ifdef DRUM_EXP_PERF_CNT_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    // Count completed output transfers; wraps naturally at 2^32.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (s2_valid_q && out_ready) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_cnt = perf_cnt_q;
`endif

endmodule
